// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage. Runs loads and stores over a simple
// req/gnt/rvalid data-memory bus, formats load data, raises the branch
// redirect, and aborts a bus transaction that makes no progress for
// TIMEOUT_CYC cycles.
// Optional build macro MISALIGN_TRAP_EN: adds misalign_o and traps misaligned
// halfword/word accesses instead of truncating their address bits.
module memory_access #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_rdata_i,
  input  logic [31:0] instruction_addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        Branch_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        condition_en_i,
  output logic        stall_o,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_RegWrite_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        mem_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

  state_t      state;
  logic [7:0]  tmo_cnt;

  logic        mem_op;
  logic        is_store;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        timeout;
  logic [1:0]  lane;
  logic [31:0] shifted;
  logic [31:0] load_fmt;

  logic        req;
  logic        stall;
  logic        pass_thru;
  logic        trap;
  logic        store_done;
  logic        load_done;
  logic        abort;
  logic        go_req;
  logic        go_wait;

  // Decode the access: width class, byte lane used inside the word, alignment
  always_comb begin
    mem_op   = in_valid_i & (MemRead_i | MemWrite_i);
    is_store = MemWrite_i;
    is_byte  = (funct3_i == 3'd0) | (~is_store & (funct3_i == 3'd4));
    is_half  = (funct3_i == 3'd1) | (~is_store & (funct3_i == 3'd5));
    if (is_byte) begin
      lane = alu_result_i[1:0];
    end else if (is_half) begin
      lane = {alu_result_i[1], 1'b0};
    end else begin
      lane = 2'b00;
    end
`ifdef MISALIGN_TRAP_EN
    misaligned = (is_half & alu_result_i[0]) |
                 (~is_byte & ~is_half & (alu_result_i[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    timeout = (tmo_cnt == TMO_LIMIT);
  end

  // Bus address, write enable, byte enables and lane-replicated store data
  always_comb begin
    dmem_addr_o = {alu_result_i[31:2], 2'b00};
    dmem_we_o   = mem_op & is_store;
    if (is_byte) begin
      dmem_be_o    = 4'b0001 << lane;
      dmem_wdata_o = {4{rs2_rdata_i[7:0]}};
    end else if (is_half) begin
      dmem_be_o    = lane[1] ? 4'b1100 : 4'b0011;
      dmem_wdata_o = {2{rs2_rdata_i[15:0]}};
    end else begin
      dmem_be_o    = 4'b1111;
      dmem_wdata_o = rs2_rdata_i;
    end
  end

  // Align returned read data to bit 0 and sign/zero extend by funct3
  always_comb begin
    shifted = dmem_rdata_i >> {lane, 3'b000};
    case (funct3_i)
      3'd0:    load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_fmt = {24'h000000, shifted[7:0]};
      3'd5:    load_fmt = {16'h0000, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  // Per-state bus handshake: decide request, stall and what finishes this cycle
  always_comb begin
    req        = 1'b0;
    stall      = 1'b0;
    pass_thru  = 1'b0;
    trap       = 1'b0;
    store_done = 1'b0;
    load_done  = 1'b0;
    abort      = 1'b0;
    go_req     = 1'b0;
    go_wait    = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          pass_thru = 1'b1;
        end else if (misaligned) begin
          trap = 1'b1;
        end else begin
          req = 1'b1;
          if (dmem_gnt_i) begin
            if (is_store) begin
              store_done = 1'b1;
            end else begin
              go_wait = 1'b1;
              stall   = 1'b1;
            end
          end else begin
            go_req = 1'b1;
            stall  = 1'b1;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          abort = 1'b1;
        end else begin
          req = 1'b1;
          if (dmem_gnt_i) begin
            if (is_store) begin
              store_done = 1'b1;
            end else begin
              go_wait = 1'b1;
              stall   = 1'b1;
            end
          end else begin
            stall = 1'b1;
          end
        end
      end
      WAIT: begin
        if (timeout) begin
          abort = 1'b1;
        end else if (dmem_rvalid_i) begin
          load_done = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Request and stall vanish the moment reset asserts, even with a held memory op
  always_comb begin
    dmem_req_o      = req & ~rst_i;
    stall_o         = stall & ~rst_i;
    pc_src_o        = in_valid_i & Branch_i & condition_en_i;
    branch_target_o = instruction_addr_i;
  end

  // FSM, progress timeout counter and registered writeback outputs
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      tmo_cnt       <= 8'd0;
      wb_valid_o    <= 1'b0;
      wb_RegWrite_o <= 1'b0;
      wb_rd_o       <= 5'd0;
      wb_data_o     <= 32'd0;
      mem_err_o     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_o    <= 1'b0;
`endif
    end else begin
      if (go_req) begin
        state   <= REQ;
        tmo_cnt <= 8'd0;
      end else if (go_wait) begin
        state   <= WAIT;
        tmo_cnt <= 8'd0;
      end else if (store_done | load_done | abort) begin
        state   <= IDLE;
        tmo_cnt <= 8'd0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      wb_valid_o    <= pass_thru ? in_valid_i : (store_done | load_done | abort | trap);
      wb_RegWrite_o <= (pass_thru & in_valid_i & RegWrite_i) | (load_done & RegWrite_i);
      mem_err_o     <= abort;
`ifdef MISALIGN_TRAP_EN
      misalign_o    <= trap;
`endif
      if (pass_thru | store_done | load_done | abort | trap) begin
        wb_rd_o   <= rd_i;
        wb_data_o <= (load_done & MemtoReg_i) ? load_fmt : alu_result_i;
      end
    end
  end

endmodule
